// File: rtl/mdu_unit_pkg.sv
// Shared pipeline constants: ALU and MDU operation encodings plus the
// default multiply/divide latencies used by the E-stage units.
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        MDU_ST_IDLE = 1'b0,
        MDU_ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // True for the operations that occupy the unit for a multi-cycle period.
    function automatic logic is_muldiv(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit with HI/LO registers. The result is computed
// in the start cycle and held in pending registers; a down-counter models
// the multi-cycle latency before it is committed to HI/LO.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src_A,
    input  logic [31:0] src_B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] E_HILO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

    mdu_op_e    op;
    mdu_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic             accept;
    logic             commit;
    logic             mthi_wr;
    logic             mtlo_wr;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      quot_s, rem_s;
    logic [31:0]      quot_u, rem_u;
    logic [31:0]      res_hi, res_lo;
    logic             res_wr;
    logic             res_is_mult;

    assign op = mdu_op_e'(MDUOp);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on an accepted start, return on the last busy cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_ST_IDLE: if (start && is_muldiv(op)) state_d = MDU_ST_BUSY;
            MDU_ST_BUSY: if (cnt_q == CNT_W'(1)) state_d = MDU_ST_IDLE;
            default:     state_d = MDU_ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag and the strobes that steer the datapath.
    always_comb begin
        busy    = (state_q == MDU_ST_BUSY);
        accept  = (state_q == MDU_ST_IDLE) && start && is_muldiv(op);
        commit  = (state_q == MDU_ST_BUSY) && (cnt_q == CNT_W'(1));
        mthi_wr = (state_q == MDU_ST_IDLE) && !start && (op == MDU_MTHI);
        mtlo_wr = (state_q == MDU_ST_IDLE) && !start && (op == MDU_MTLO);
    end

    // Arithmetic on the forwarded operands; evaluated every cycle, used only on accept.
    always_comb begin
        prod_s = $signed({{32{src_A[31]}}, src_A}) * $signed({{32{src_B[31]}}, src_B});
        prod_u = {32'b0, src_A} * {32'b0, src_B};
        quot_u = src_A / src_B;
        rem_u  = src_A % src_B;
        // The most-negative / -1 quotient overflows 32 bits; pin it explicitly.
        if (src_A == 32'h8000_0000 && src_B == 32'hFFFF_FFFF) begin
            quot_s = 32'h8000_0000;
            rem_s  = '0;
        end else begin
            quot_s = $signed(src_A) / $signed(src_B);
            rem_s  = $signed(src_A) % $signed(src_B);
        end
    end

    // Select the pending result; divide by zero commits nothing.
    always_comb begin
        res_hi      = '0;
        res_lo      = '0;
        res_wr      = 1'b0;
        res_is_mult = 1'b0;
        case (op)
            MDU_MULT: begin
                res_hi      = prod_s[63:32];
                res_lo      = prod_s[31:0];
                res_wr      = 1'b1;
                res_is_mult = 1'b1;
            end
            MDU_MULTU: begin
                res_hi      = prod_u[63:32];
                res_lo      = prod_u[31:0];
                res_wr      = 1'b1;
                res_is_mult = 1'b1;
            end
            MDU_DIV: begin
                res_hi = rem_s;
                res_lo = quot_s;
                res_wr = (src_B != '0);
            end
            MDU_DIVU: begin
                res_hi = rem_u;
                res_lo = quot_u;
                res_wr = (src_B != '0);
            end
            default: ;
        endcase
    end

    // Next values for counter, pending and committed HI/LO registers.
    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (accept) begin
            cnt_d     = res_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_wr_d = res_wr;
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (commit && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end
        if (mthi_wr) hi_d = src_A;
        if (mtlo_wr) lo_d = src_A;
    end

    // Datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Read port for mfhi/mflo, always from the committed registers.
    always_comb begin
        case (op)
            MDU_MFHI: E_HILO = hi_q;
            MDU_MFLO: E_HILO = lo_q;
            default:  E_HILO = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboarded bench for mdu_unit: stimulus pushes expected busy lengths and
// expected HI/LO reads; a negedge monitor pops and compares.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src_A, src_B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] E_HILO;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .src_A  (src_A),
        .src_B  (src_B),
        .MDUOp  (MDUOp),
        .start  (start),
        .busy   (busy),
        .E_HILO (E_HILO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    rd_t         rd_q[$];
    int          busy_q[$];
    logic        chk_en;
    logic [31:0] m_hi, m_lo;
    int          run = 0;
    rd_t         mon_e;
    int          mon_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: busy run lengths and E_HILO reads against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            if (busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                if (busy_q.size() == 0) begin
                    check("busy_unexpected", 32'(run), 32'd0);
                end else begin
                    mon_len = busy_q.pop_front();
                    check("busy_len", 32'(run), 32'(mon_len));
                end
                run = 0;
            end
            if (chk_en) begin
                if (rd_q.size() == 0) begin
                    check("rd_underflow", E_HILO, 32'hxxxx_xxxx);
                end else begin
                    mon_e = rd_q.pop_front();
                    check(mon_e.name, E_HILO, mon_e.exp);
                end
            end
        end
    end

    // Reference model from the arithmetic definition of each operation.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] res, output bit wr);
        longint          p, q, r;
        longint unsigned pu;
        logic [63:0]     wq, wr64;
        res = '0;
        wr  = 1'b0;
        case (op)
            MDU_MULT: begin
                p   = longint'($signed(a)) * longint'($signed(b));
                res = p;
                wr  = 1'b1;
            end
            MDU_MULTU: begin
                pu  = longint'(a) * longint'(b);
                res = pu;
                wr  = 1'b1;
            end
            MDU_DIV: if (b != 0) begin
                q    = longint'($signed(a)) / longint'($signed(b));
                r    = longint'($signed(a)) % longint'($signed(b));
                wq   = q;
                wr64 = r;
                res  = {wr64[31:0], wq[31:0]};
                wr   = 1'b1;
            end
            MDU_DIVU: if (b != 0) begin
                res = {a % b, a / b};
                wr  = 1'b1;
            end
            default: ;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start  = 1'b0;
        MDUOp  = MDU_NONE;
        chk_en = 1'b0;
    endtask

    task automatic read_hilo(input string tag);
        MDUOp = MDU_MFHI; chk_en = 1'b1;
        rd_q.push_back('{{tag, "_hi"}, m_hi});
        step();
        MDUOp = MDU_MFLO;
        rd_q.push_back('{{tag, "_lo"}, m_lo});
        step();
        MDUOp = MDU_NONE;
        rd_q.push_back('{{tag, "_none"}, 32'd0});
        step();
        idle_inputs();
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        MDUOp = op; src_A = v; start = 1'b0;
        step();
        if (op == MDU_MTHI) m_hi = v; else m_lo = v;
        idle_inputs();
    endtask

    // mode 0: plain; 1: mfhi every busy cycle; 2: stray start and mthi while busy
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
        int          n;
        logic [63:0] res;
        bit          wr;
        n = (op == MDU_MULT || op == MDU_MULTU) ? MC : DC;
        model(op, a, b, res, wr);
        busy_q.push_back(n);
        MDUOp = op; src_A = a; src_B = b; start = 1'b1;
        step();
        src_A = $urandom; src_B = $urandom;
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            if (mode == 1) begin
                MDUOp = MDU_MFHI; chk_en = 1'b1;
                rd_q.push_back('{"hi_during_busy", m_hi});
            end
            if (mode == 2 && i == 1) begin
                start = 1'b1; MDUOp = MDU_DIV;
            end
            if (mode == 2 && i == 2) begin
                MDUOp = MDU_MTHI; src_A = 32'hDEAD_BEEF;
            end
            step();
        end
        idle_inputs();
        if (wr) begin
            m_hi = res[63:32];
            m_lo = res[31:0];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        rst_n = 1'b0; src_A = '0; src_B = '0;
        idle_inputs();
        m_hi = '0; m_lo = '0;
        step(); step();
        check("reset_busy", {31'b0, busy}, 32'd0);
        MDUOp = MDU_MFHI; #1;
        check("reset_hi", E_HILO, 32'd0);
        MDUOp = MDU_MFLO; #1;
        check("reset_lo", E_HILO, 32'd0);
        MDUOp = MDU_NONE;
        step();
        rst_n = 1'b1;
        step();

        run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 0);      read_hilo("mult_neg2x3");
        run_op(MDU_DIVU, 32'd100, 32'd7, 0);            read_hilo("divu_100_7");
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);       read_hilo("div_m7_2");
        mt(MDU_MTHI, 32'h1234);
        mt(MDU_MTLO, 32'h5678);                         read_hilo("mt_write");
        run_op(MDU_DIV, 32'h0BAD_0BAD, 32'd0, 0);       read_hilo("div_by_zero");
        run_op(MDU_DIVU, 32'hFFFF_0000, 32'd0, 0);      read_hilo("divu_by_zero");
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0); read_hilo("div_overflow");
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); read_hilo("multu_max");
        run_op(MDU_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1);  read_hilo("mfhi_across_commit");
        run_op(MDU_DIVU, 32'hCAFE_F00D, 32'd13, 2);     read_hilo("ignore_in_busy");

        // Reset in busy cycle 3 of a multiply discards the result.
        mt(MDU_MTHI, 32'h5555_AAAA);
        MDUOp = MDU_MULT; src_A = 32'd7; src_B = 32'd9; start = 1'b1;
        step();
        idle_inputs(); MDUOp = MDU_MFHI;
        step(); step();
        rst_n = 1'b0; #1;
        check("busy_async_reset", {31'b0, busy}, 32'd0);
        check("hi_async_reset", E_HILO, 32'd0);
        m_hi = '0; m_lo = '0;
        idle_inputs();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        read_hilo("no_commit_after_reset");

        // First start right after reset release.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        run_op(MDU_MULT, 32'd40000, 32'd70000, 0);      read_hilo("start_after_reset");

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 4) == 0)
                mt(($urandom_range(0, 1) == 0) ? MDU_MTHI : MDU_MTLO, $urandom);
            case ($urandom_range(0, 3))
                0: rop = MDU_MULT;
                1: rop = MDU_MULTU;
                2: rop = MDU_DIV;
                default: rop = MDU_DIVU;
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(rop, ra, rb, 0);
            read_hilo("random");
        end

        step(); step();
        check("busy_queue_drained", 32'(busy_q.size()), 32'd0);
        check("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
